// File: rtl/uart_tx_engine.sv
// 8N1/8N2 UART serializer fed by the reply-FIFO drain stage; LSB first, fixed baud.
// Define UART_TX_PARITY_EN to insert a parity bit (sense set by PARITY_ODD).
module uart_tx_engine #(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned BAUD        = 115_200,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned PARITY_ODD  = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       txd,
    output logic       busy,
    output logic       tx_done
);

    localparam int unsigned CLKS_PER_BIT = (CLK_FREQ_HZ + BAUD / 2) / BAUD;
    localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_tx_engine: CLKS_PER_BIT must be at least 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_engine: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD > 1) begin : g_bad_parity_odd
        $error("uart_tx_engine: PARITY_ODD must be 0 or 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state,    state_nxt;
    logic [CNT_W-1:0] baud_cnt, baud_nxt;
    logic [2:0]       bit_cnt,  bit_nxt;
    logic             stop_cnt, stop_nxt;
    logic [7:0]       shift,    shift_nxt;
    logic             txd_nxt;
    logic             busy_nxt;
    logic             done_nxt;
    logic             wrap;
`ifdef UART_TX_PARITY_EN
    logic             par_bit,  par_nxt;
`endif

    // Ready drops in the same cycle valid arrives so the registered drain stage pops only once.
    assign tx_ready = (state == IDLE) && !tx_valid;
    assign wrap     = (baud_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            shift    <= '0;
            txd      <= 1'b1;
            busy     <= 1'b0;
            tx_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_cnt  <= bit_nxt;
            stop_cnt <= stop_nxt;
            shift    <= shift_nxt;
            txd      <= txd_nxt;
            busy     <= busy_nxt;
            tx_done  <= done_nxt;
`ifdef UART_TX_PARITY_EN
            par_bit  <= par_nxt;
`endif
        end
    end

    // Next-state and next-output logic; the line bit advances on each baud wrap.
    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_cnt;
        stop_nxt  = stop_cnt;
        shift_nxt = shift;
        txd_nxt   = txd;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_nxt   = par_bit;
`endif

        if (state != IDLE) begin
            baud_nxt = wrap ? '0 : baud_cnt + CNT_W'(1);
        end

        case (state)
            IDLE: begin
                txd_nxt = 1'b1;
                if (tx_valid) begin
                    state_nxt = START;
                    shift_nxt = tx_data;
                    txd_nxt   = 1'b0;
                    busy_nxt  = 1'b1;
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                    stop_nxt  = 1'b0;
`ifdef UART_TX_PARITY_EN
                    par_nxt   = (^tx_data) ^ (PARITY_ODD != 0);
`endif
                end
            end
            START: begin
                if (wrap) begin
                    state_nxt = DATA;
                    txd_nxt   = shift[0];
                end
            end
            DATA: begin
                if (wrap) begin
                    if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_nxt = PARITY;
                        txd_nxt   = par_bit;
`else
                        state_nxt = STOP;
                        txd_nxt   = 1'b1;
`endif
                    end else begin
                        shift_nxt = {1'b0, shift[7:1]};
                        txd_nxt   = shift[1];
                        bit_nxt   = bit_cnt + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (wrap) begin
                    state_nxt = STOP;
                    txd_nxt   = 1'b1;
                end
            end
`endif
            STOP: begin
                if (wrap) begin
                    if (stop_cnt == STOP_LAST) begin
                        state_nxt = IDLE;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end else begin
                        stop_nxt = stop_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                txd_nxt   = 1'b1;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: directed steps, frame-decoding monitor and expected-byte scoreboard.
module tb_uart_tx_engine;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_valid = 1'b0;
    logic       sel = 1'b0;
    logic [7:0] tx_data = 8'h00;

    logic v1, v2, r1, r2, txd1, txd2, b1, b2, d1, d2;
    logic txd_m, busy_m, done_m, ready_m;

    assign v1      = tx_valid & ~sel;
    assign v2      = tx_valid & sel;
    assign txd_m   = sel ? txd2 : txd1;
    assign busy_m  = sel ? b2 : b1;
    assign done_m  = sel ? d2 : d1;
    assign ready_m = sel ? r2 : r1;

    uart_tx_engine #(.CLK_FREQ_HZ(1_000_000), .BAUD(250_000), .STOP_BITS(1), .PARITY_ODD(0)) u_dut1 (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(v1),
        .tx_ready(r1), .txd(txd1), .busy(b1), .tx_done(d1)
    );

    uart_tx_engine #(.CLK_FREQ_HZ(1_000_000), .BAUD(250_000), .STOP_BITS(2), .PARITY_ODD(1)) u_dut2 (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(v2),
        .tx_ready(r2), .txd(txd2), .busy(b2), .tx_done(d2)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int frames = 0;
    int pops = 0;
    logic [7:0] exp_q[$];
    logic [7:0] fifo[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected txd, one bit per clock cycle, for a whole frame.
    function automatic logic [63:0] build(input logic [7:0] b, input int sb, input logic odd);
        logic [63:0] v;
        logic [11:0] seq;
        int n;
        v = '1;
        seq = '1;
        seq[0] = 1'b0;
        seq[8:1] = b;
        n = 9;
        if (PB == 1) begin
            seq[9] = (^b) ^ odd;
            n = 10;
        end
        n = n + sb;
        for (int i = 0; i < n; i++)
            for (int c = 0; c < CPB; c++)
                v[i*CPB + c] = seq[i];
        return v;
    endfunction

    // Monitor: decodes each frame cycle by cycle and checks it against the scoreboard.
    initial begin : monitor
        logic [63:0] got, exp;
        logic [7:0] e;
        int sb, nb;
        bit aborted, side_ok;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && txd_m === 1'b0) begin
                sb = sel ? 2 : 1;
                nb = 9 + PB + sb;
                got = '1;
                aborted = 1'b0;
                side_ok = 1'b1;
                for (int i = 0; i < nb * CPB; i++) begin
                    if (i > 0) @(negedge clk);
                    if (rst !== 1'b0) begin
                        aborted = 1'b1;
                        break;
                    end
                    got[i] = txd_m;
                    if (busy_m !== 1'b1 || done_m !== 1'b0) side_ok = 1'b0;
                end
                if (!aborted) begin
                    @(negedge clk);
                    chk("end_done", done_m, 1);
                    chk("end_busy", busy_m, 0);
                    chk("busy_during_frame", side_ok, 1);
                    chk("sb_nonempty", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        exp = build(e, sb, sel);
                        chk($sformatf("frame_%02h", e), got, exp);
                    end
                    frames++;
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic send(input logic [7:0] b, input bit push);
        tx_data = b;
        tx_valid = 1'b1;
        #1;
        chk("ready_low_on_valid", ready_m, 0);
        if (push) exp_q.push_back(b);
        @(negedge clk);
        chk("txd_start_latency", txd_m, 0);
        chk("busy_rise", busy_m, 1);
        tx_valid = 1'b0;
        tx_data = ~b;
    endtask

    task automatic wait_frames(input int n, input int budget);
        for (int c = 0; c < budget && frames < n; c++) @(negedge clk);
        chk("frame_count", frames, n);
    endtask

    initial begin : stimulus
        int n0;
        bit rdy_bad;

        // reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_txd1", txd1, 1);
        chk("rst_busy1", b1, 0);
        chk("rst_done1", d1, 0);
        chk("rst_ready1", r1, 1);
        chk("rst_txd2", txd2, 1);
        chk("rst_busy2", b2, 0);
        rst = 1'b0;
        @(negedge clk);

        // basic 8N1 frame
        send(8'h55, 1'b1);
        wait_frames(1, 60);

        // drain stage integration: registered pop on ready
        fifo = '{8'hA3, 8'h0F, 8'hFF};
        pops = 0;
        for (int c = 0; c < 140; c++) begin
            @(negedge clk);
            if (ready_m === 1'b1 && fifo.size() > 0) begin
                tx_data = fifo.pop_front();
                tx_valid = 1'b1;
                exp_q.push_back(tx_data);
                pops++;
            end else begin
                tx_valid = 1'b0;
            end
            #1;
            if (tx_valid) chk("drain_ready_low", ready_m, 0);
        end
        tx_valid = 1'b0;
        wait_frames(4, 60);
        chk("drain_pops", pops, 3);

        // valid while busy is ignored
        n0 = frames + 1;
        send(8'hC4, 1'b1);
        repeat (9) @(negedge clk);
        tx_data = 8'h12;
        tx_valid = 1'b1;
        #1;
        chk("busy_valid_ready", ready_m, 0);
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data = 8'h00;
        rdy_bad = 1'b0;
        for (int c = 0; c < 60 && frames < n0; c++) begin
            @(negedge clk);
            if (busy_m === 1'b1 && ready_m !== 1'b0) rdy_bad = 1'b1;
        end
        chk("ready_low_while_busy", rdy_bad, 0);
        chk("frame_count_c4", frames, n0);
        chk("ready_back_idle", ready_m, 1);
        repeat (60) @(negedge clk);
        chk("no_extra_frame", frames, n0);
        chk("idle_txd", txd_m, 1);

        // reset during data bit 3 drops the frame
        send(8'h00, 1'b0);
        repeat (17) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_txd", txd_m, 1);
        chk("midrst_busy", busy_m, 0);
        chk("midrst_done", done_m, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", ready_m, 1);
        send(8'h81, 1'b1);
        wait_frames(n0 + 1, 60);

        // two stop bits
        sel = 1'b1;
        @(negedge clk);
        send(8'hF0, 1'b1);
        wait_frames(n0 + 2, 70);

        // parity byte on odd-sense instance, then even-sense instance
        send(8'h07, 1'b1);
        wait_frames(n0 + 3, 70);
        sel = 1'b0;
        @(negedge clk);
        send(8'h07, 1'b1);
        wait_frames(n0 + 4, 70);
        chk("sb_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
